// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields into instruction words behind a tagged output FIFO
module instr_encoder #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              addr_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [7:0]        illegal_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [31:0]       instr_q [DEPTH];
  logic [ADDR_W-1:0] tag_q   [DEPTH];
  logic [PW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d, tag;
  logic              err_q;
  logic [7:0]        cnt_q;
  logic [31:0]       enc;
  logic              legal, accept, push, pop, bad;
  logic              i_ok, b_ok, u_ok;
  assign i_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign b_ok = ~in_imm[0] & ((&in_imm[31:12]) | ~(|in_imm[31:12]));
  assign u_ok = ~(|in_imm[11:0]);
  // pick the instruction format from the opcode and judge whether the immediate fits it
  always_comb begin
    enc   = '0;
    legal = 1'b0;
    case (in_opcode)
      5'b00000, 5'b00100: begin
        enc   = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode, 2'b11};
        legal = i_ok;
      end
      5'b01000: begin
        enc   = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode, 2'b11};
        legal = i_ok;
      end
      5'b11000: begin
        enc   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], in_opcode, 2'b11};
        legal = b_ok;
      end
      5'b01100: begin
        enc   = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode, 2'b11};
        legal = 1'b1;
      end
      5'b01101: begin
        enc   = {in_imm[31:12], in_rd, in_opcode, 2'b11};
        legal = u_ok;
      end
      default: begin
        enc   = '0;
        legal = 1'b0;
      end
    endcase
  end
  // in_ready is held low while reset is asserted and otherwise depends only on FIFO occupancy
  assign in_ready  = rst_n & (count_q < CW'(DEPTH));
  assign accept    = in_valid & in_ready;
  assign push      = accept & legal;
  assign bad       = accept & ~legal;
  assign out_valid = count_q != '0;
  assign pop       = out_valid & out_ready;
  assign out_instr = out_valid ? instr_q[rd_q] : '0;
  assign out_addr  = out_valid ? tag_q[rd_q] : '0;
  assign err         = err_q;
  assign illegal_cnt = cnt_q;
  // a clear in the same cycle as a legal accept tags that word 0 and leaves the counter at 1
  assign tag     = addr_clr ? '0 : addr_q;
  assign addr_d  = push ? tag + 1'b1 : tag;
  assign count_d = count_q + CW'(push) - CW'(pop);
  // FIFO storage needs no reset since the head is masked by out_valid
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_q] <= enc;
      tag_q[wr_q]   <= tag;
    end
  end
  // pointers, occupancy, address counter and sticky error bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      wr_q    <= wr_q + PW'(push);
      rd_q    <= rd_q + PW'(pop);
      count_q <= count_d;
      addr_q  <= addr_d;
      err_q   <= err_q | bad;
      cnt_q   <= cnt_q + 8'(bad & ~(&cnt_q));
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed checks of encoding, legality, FIFO backpressure, addressing and reset
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        addr_clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_opcode = '0, in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [1:0]  out_addr;
  logic        err;
  logic [7:0]  illegal_cnt;
  int total = 0, passed = 0;

  instr_encoder #(.DEPTH(2), .ADDR_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .addr_clr(addr_clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .err(err), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b1; addr_clr = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic set_fields(input logic [4:0] op, rd, rs1, rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm);
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic send(input logic [4:0] op, rd, rs1, rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm);
    @(negedge clk);
    set_fields(op, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b exp 0", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", out_valid); else passed++;
    total++; if (out_instr !== 32'h0) $display("FAIL rst_out_instr got %h exp 0", out_instr); else passed++;
    total++; if ({err, illegal_cnt} !== 9'h0) $display("FAIL rst_err_cnt got %b/%0d exp 0/0", err, illegal_cnt); else passed++;
    do_reset();
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL rel_in_ready got %b exp 1", in_ready); else passed++;
  endtask

  task automatic test_basic();
    do_reset();
    send(5'b00100, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 32'd123);
    total++; if (out_valid !== 1'b1) $display("FAIL addi_valid got %b exp 1", out_valid); else passed++;
    total++; if (out_instr !== 32'h07B08113) $display("FAIL addi_instr got %h exp 07b08113", out_instr); else passed++;
    total++; if (out_addr !== 2'd0) $display("FAIL addi_addr got %0d exp 0", out_addr); else passed++;
    send(5'b01100, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    total++; if (out_instr !== 32'h002081B3) $display("FAIL add_instr got %h exp 002081b3", out_instr); else passed++;
    total++; if (out_addr !== 2'd1) $display("FAIL add_addr got %0d exp 1", out_addr); else passed++;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL drain_valid got %b exp 0", out_valid); else passed++;
  endtask

  task automatic test_formats();
    do_reset();
    send(5'b01000, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    total++; if (out_instr !== 32'h0020A423) $display("FAIL sw_instr got %h exp 0020a423", out_instr); else passed++;
    send(5'b01101, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    total++; if (out_instr !== 32'h123452B7) $display("FAIL lui_instr got %h exp 123452b7", out_instr); else passed++;
    send(5'b11000, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4);
    total++; if (out_instr !== 32'hFE208EE3) $display("FAIL beq_instr got %h exp fe208ee3", out_instr); else passed++;
    total++; if (out_addr !== 2'd2) $display("FAIL beq_addr got %0d exp 2", out_addr); else passed++;
    send(5'b01100, 5'd3, 5'd1, 5'd2, 3'd5, 7'h20, 32'd0);
    total++; if (out_instr !== 32'h4020D1B3) $display("FAIL sra_instr got %h exp 4020d1b3", out_instr); else passed++;
  endtask

  task automatic test_illegal();
    do_reset();
    send(5'b11000, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    total++; if (out_valid !== 1'b0) $display("FAIL bodd_valid got %b exp 0", out_valid); else passed++;
    total++; if (err !== 1'b1) $display("FAIL bodd_err got %b exp 1", err); else passed++;
    total++; if (illegal_cnt !== 8'd1) $display("FAIL bodd_cnt got %0d exp 1", illegal_cnt); else passed++;
    send(5'b00100, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 32'd2048);
    total++; if (illegal_cnt !== 8'd2) $display("FAIL i2048_cnt got %0d exp 2", illegal_cnt); else passed++;
    send(5'b01101, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001);
    total++; if (illegal_cnt !== 8'd3) $display("FAIL ulow_cnt got %0d exp 3", illegal_cnt); else passed++;
    send(5'b00101, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
    total++; if (illegal_cnt !== 8'd4) $display("FAIL badop_cnt got %0d exp 4", illegal_cnt); else passed++;
    send(5'b11000, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
    total++; if (illegal_cnt !== 8'd5) $display("FAIL b4096_cnt got %0d exp 5", illegal_cnt); else passed++;
    send(5'b01000, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2049);
    total++; if (illegal_cnt !== 8'd6) $display("FAIL sneg_cnt got %0d exp 6", illegal_cnt); else passed++;
    send(5'b00100, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 32'd123);
    total++; if (out_instr !== 32'h07B08113) $display("FAIL after_ill_instr got %h exp 07b08113", out_instr); else passed++;
    total++; if (out_addr !== 2'd0) $display("FAIL after_ill_addr got %0d exp 0", out_addr); else passed++;
    total++; if (err !== 1'b1) $display("FAIL err_sticky got %b exp 1", err); else passed++;
  endtask

  task automatic test_boundaries();
    do_reset();
    send(5'b00100, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048);
    total++; if (out_instr !== 32'h80000013) $display("FAIL imin_instr got %h exp 80000013", out_instr); else passed++;
    send(5'b00100, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047);
    total++; if (out_instr !== 32'h7FF00013) $display("FAIL imax_instr got %h exp 7ff00013", out_instr); else passed++;
    send(5'b11000, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094);
    total++; if (out_instr !== 32'h7E000FE3) $display("FAIL bmax_instr got %h exp 7e000fe3", out_instr); else passed++;
    send(5'b11000, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4096);
    total++; if (out_instr !== 32'h80000063) $display("FAIL bmin_instr got %h exp 80000063", out_instr); else passed++;
    total++; if (err !== 1'b0) $display("FAIL bound_err got %b exp 0", err); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0;
    @(negedge clk);
    set_fields(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    total++; if (out_instr !== 32'h00100093) $display("FAIL bp_first got %h exp 00100093", out_instr); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_ready1 got %b exp 1", in_ready); else passed++;
    set_fields(5'b00100, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready got %b exp 0", in_ready); else passed++;
    set_fields(5'b00100, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    @(posedge clk); #1;
    total++; if (out_instr !== 32'h00100093 || out_addr !== 2'd0) $display("FAIL bp_head_hold got %h/%0d exp 00100093/0", out_instr, out_addr); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL bp_stall_ready got %b exp 0", in_ready); else passed++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (out_instr !== 32'h00200113 || out_addr !== 2'd1) $display("FAIL bp_second got %h/%0d exp 00200113/1", out_instr, out_addr); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_back got %b exp 1", in_ready); else passed++;
    @(posedge clk); #1;
    total++; if (out_instr !== 32'h00300193 || out_addr !== 2'd2) $display("FAIL bp_third got %h/%0d exp 00300193/2", out_instr, out_addr); else passed++;
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL bp_empty got %b exp 0", out_valid); else passed++;
  endtask

  task automatic test_addr_wrap();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
      total++; if (out_addr !== 2'(i)) $display("FAIL wrap_addr%0d got %0d exp %0d", i, out_addr, i % 4); else passed++;
    end
    addr_clr = 1'b1;
    send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
    addr_clr = 1'b0;
    total++; if (out_addr !== 2'd0) $display("FAIL clr_accept_addr got %0d exp 0", out_addr); else passed++;
    send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd10);
    total++; if (out_addr !== 2'd1) $display("FAIL clr_next_addr got %0d exp 1", out_addr); else passed++;
    @(negedge clk) addr_clr = 1'b1;
    @(posedge clk); #1 addr_clr = 1'b0;
    send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd11);
    total++; if (out_addr !== 2'd0) $display("FAIL clr_alone_addr got %0d exp 0", out_addr); else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    send(5'b11111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    send(5'b00100, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    total++; if (out_valid !== 1'b1 || err !== 1'b1 || illegal_cnt !== 8'd1) $display("FAIL pre_rst got %b/%b/%0d exp 1/1/1", out_valid, err, illegal_cnt); else passed++;
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_instr !== 32'h0) $display("FAIL async_out got %b/%h exp 0/0", out_valid, out_instr); else passed++;
    total++; if (err !== 1'b0 || illegal_cnt !== 8'd0) $display("FAIL async_err got %b/%0d exp 0/0", err, illegal_cnt); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL async_ready got %b exp 0", in_ready); else passed++;
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    total++; if (out_addr !== 2'd0) $display("FAIL async_addr got %0d exp 0", out_addr); else passed++;
  endtask

  task automatic test_saturate();
    do_reset();
    repeat (260) send(5'b11111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    total++; if (illegal_cnt !== 8'd255) $display("FAIL sat_cnt got %0d exp 255", illegal_cnt); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL sat_valid got %b exp 0", out_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_formats();
    test_illegal();
    test_boundaries();
    test_back_to_back();
    test_addr_wrap();
    test_async_reset();
    test_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
